// File: rtl/relu_tile_streamer_if.sv
// Tile/row streaming bus for relu_tile_streamer.
// Carries both handshakes of the block:
//   in_valid/in_ready/in_data      : one ROWS x COLS signed tile, [row][col]
//   out_valid/out_ready/out_data   : one COLS-lane signed row per beat, [col]
//   out_row_idx/out_last           : row index of the current beat and last-row flag
//   zero_cnt                       : zeros in the held tile (0 unless the
//                                    RELU_TILE_STREAMER_SPARSITY_CNT_EN build is used)
// Modports:
//   slave  : the streamer itself (accepts tiles, produces rows)
//   master : the environment (produces tiles, consumes rows)
interface relu_tile_streamer_if #(
  parameter int ROWS = 15,
  parameter int COLS = 16,
  parameter int DW   = 8
);
  localparam int RIW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int ZW  = $clog2(ROWS * COLS + 1);

  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data [ROWS][COLS];
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data [COLS];
  logic [RIW-1:0]       out_row_idx;
  logic                 out_last;
  logic [ZW-1:0]        zero_cnt;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_row_idx, out_last, zero_cnt
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_row_idx, out_last, zero_cnt
  );
endinterface

// File: rtl/relu_tile_streamer.sv
// relu_tile_streamer
// Consumer end of the ReLU output array: captures one ROWS x COLS signed
// activation tile in a single handshake and replays it downstream one row
// per beat (row 0 first) with a last-row flag.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : relu_tile_streamer_if.slave (tile input, row output, zero_cnt)
// Optional build macro: RELU_TILE_STREAMER_SPARSITY_CNT_EN
//   defined   -> zero_cnt holds the number of zero elements in the held tile,
//                loaded on tile accept
//   undefined -> zero_cnt is tied to 0 and no counting logic exists
// Elements pass through bit-exact; no arithmetic is applied to the data.
module relu_tile_streamer #(
  parameter int ROWS = 15,
  parameter int COLS = 16,
  parameter int DW   = 8
) (
  input logic clk,
  input logic rst_n,
  relu_tile_streamer_if.slave bus
);
  localparam int RIW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int ZW  = $clog2(ROWS * COLS + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [RIW-1:0]       row_idx_q;
  logic signed [DW-1:0] tile_p1 [ROWS][COLS];

  logic in_ready;
  logic out_valid;
  logic accept;
  logic beat;
  logic last_row;

  assign last_row = (row_idx_q == RIW'(ROWS - 1));

  // Next-state and handshake decode. in_ready/out_valid depend only on the
  // state register, so nothing from the in_* side reaches the out_* side
  // within a cycle.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    beat      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          beat = 1'b1;
          if (last_row) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Row pointer: cleared on accept and after the last beat, so it never
  // moves without a downstream handshake and never exceeds ROWS-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_idx_q <= '0;
    end else if (accept) begin
      row_idx_q <= '0;
    end else if (beat) begin
      if (last_row) begin
        row_idx_q <= '0;
      end else begin
        row_idx_q <= row_idx_q + RIW'(1);
      end
    end
  end

  // ---- stage p1: tile buffer, written as a whole only on accept ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          tile_p1[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          tile_p1[r][c] <= bus.in_data[r][c];
        end
      end
    end
  end

  // Row output straight from the buffer and pointer registers; the buffer
  // is zero after reset, so out_data reads 0 until the first tile lands.
  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      bus.out_data[c] = tile_p1[row_idx_q][c];
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_row_idx = row_idx_q;
  assign bus.out_last    = out_valid && last_row;

`ifdef RELU_TILE_STREAMER_SPARSITY_CNT_EN
  logic [ZW-1:0] zeros_d;
  logic [ZW-1:0] zero_cnt_q;

  // Population count of zero elements on the incoming tile; only its value
  // in the accept cycle is ever stored.
  always_comb begin
    zeros_d = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (bus.in_data[r][c] == '0) begin
          zeros_d = zeros_d + ZW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_cnt_q <= '0;
    end else if (accept) begin
      zero_cnt_q <= zeros_d;
    end
  end

  assign bus.zero_cnt = zero_cnt_q;
`else
  assign bus.zero_cnt = '0;
`endif

endmodule

// File: tb/tb_relu_tile_streamer.sv
module tb_relu_tile_streamer;
  localparam int ROWS = 15;
  localparam int COLS = 16;
  localparam int DW   = 8;
  localparam int RW   = COLS * DW;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   cyc;

  relu_tile_streamer_if #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) bus ();

  relu_tile_streamer #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a queue of rows still owed downstream plus their
  // expected row numbers. A tile accepted by the handshake appends all its
  // rows; each downstream handshake retires the front row.
  logic [RW-1:0] exp_q[$];
  int            idx_q[$];
  int            exp_zc;
  int            acc_cyc;
  int            last_hs_cyc;
  int            n_hs;
  int            n_acc;

  logic signed [DW-1:0] tile_a [ROWS][COLS];
  logic signed [DW-1:0] tile_b [ROWS][COLS];
  logic signed [DW-1:0] tile_z [ROWS][COLS];

  function automatic int zeros_in_bus();
    int n = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (bus.in_data[r][c] == 0) n++;
    return n;
  endfunction

  always @(negedge clk) begin
    logic [RW-1:0] row;
    if (!rst_n) begin
      exp_q.delete();
      idx_q.delete();
      exp_zc = 0;
    end else begin
      check("in_ready", {bus.in_ready}, {exp_q.size() == 0});
      check("out_valid", {bus.out_valid}, {exp_q.size() != 0});
      check("zero_cnt", bus.zero_cnt, exp_zc);
      if (exp_q.size() != 0 && bus.out_valid) begin
        for (int c = 0; c < COLS; c++) row[c*DW +: DW] = bus.out_data[c];
        check("row_data", row, exp_q[0]);
        check("row_idx", bus.out_row_idx, idx_q[0]);
        check("out_last", {bus.out_last}, {idx_q[0] == ROWS - 1});
        if (bus.out_ready) begin
          if (idx_q[0] == ROWS - 1) last_hs_cyc = cyc;
          void'(exp_q.pop_front());
          void'(idx_q.pop_front());
          n_hs++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        for (int r = 0; r < ROWS; r++) begin
          for (int c = 0; c < COLS; c++) row[c*DW +: DW] = bus.in_data[r][c];
          exp_q.push_back(row);
          idx_q.push_back(r);
        end
`ifdef RELU_TILE_STREAMER_SPARSITY_CNT_EN
        exp_zc = zeros_in_bus();
`else
        exp_zc = 0;
`endif
        acc_cyc = cyc;
        n_acc++;
      end
    end
  end

  // Presents a tile and waits for it to be taken. Returns #1 after the
  // accepting edge; in_valid stays high when keep_valid is set.
  task automatic send_tile(input int which, input bit keep_valid);
    bit ok = 0;
    @(posedge clk);
    #1;
    if (which == 0) bus.in_data = tile_a;
    else if (which == 1) bus.in_data = tile_b;
    else bus.in_data = tile_z;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!keep_valid) bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.in_ready && exp_q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) check("drain_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RW-1:0] row;
    int hs0, b_acc, a_acc, ready_back;
    bit ok;
    n_checks = 0; n_fail = 0; cyc = 0;
    exp_zc = 0; n_hs = 0; n_acc = 0; acc_cyc = 0; last_hs_cyc = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        tile_a[r][c] = 8'(r * 16 + c - 100);
        tile_b[r][c] = 8'((r * COLS + c) * 3 + 7);
        tile_z[r][c] = (r * COLS + c >= 1 && r * COLS + c <= 37) ? 8'sd0 : 8'((r + c) % 100 + 1);
      end
    end
    tile_z[0][0] = -8'sd128;
    tile_z[ROWS-1][COLS-1] = 8'sd127;

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) bus.in_data[r][c] = '0;
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", {bus.in_ready}, 1'b1);
    check("rst_out_valid", {bus.out_valid}, 1'b0);
    check("rst_out_last", {bus.out_last}, 1'b0);
    check("rst_row_idx", bus.out_row_idx, 0);
    check("rst_zero_cnt", bus.zero_cnt, 0);
    for (int c = 0; c < COLS; c++) row[c*DW +: DW] = bus.out_data[c];
    check("rst_out_data", row, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: full-rate stream
    bus.out_ready = 1'b1;
    send_tile(0, 0);
    @(negedge clk);
    check("t1_first_idx", bus.out_row_idx, 0);
    check("t1_r0c0", {bus.out_data[0]}, 8'h9C);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_last) begin ok = 1; break; end
      @(negedge clk);
    end
    check("t1_last_seen", {ok}, 1'b1);
    check("t1_last_idx", bus.out_row_idx, 14);
    check("t1_r14c15", {bus.out_data[COLS-1]}, 8'h8B);
    check("t1_r6c4_row", {bus.out_row_idx == 14}, 1'b1);
    wait_idle();
    ready_back = cyc;
    check("t1_last_latency", last_hs_cyc - acc_cyc, ROWS);
    check("t1_ready_return", ready_back - acc_cyc, ROWS + 1);
`ifdef RELU_TILE_STREAMER_SPARSITY_CNT_EN
    check("t1_zero_cnt", bus.zero_cnt, 1);
`else
    check("t1_zero_cnt", bus.zero_cnt, 0);
`endif

    // 2: stalled stream, ready pattern 1,0,0,1 then pseudo-random
    hs0 = n_hs;
    bus.out_ready = 1'b1;
    send_tile(0, 0);
    for (int i = 0; i < 300 && !(bus.in_ready && exp_q.size() == 0); i++) begin
      case (i)
        0: bus.out_ready = 1'b1;
        1, 2: bus.out_ready = 1'b0;
        3: bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    wait_idle();
    check("t2_rows_once", n_hs - hs0, ROWS);

    // 3: in_valid held across two tiles
    send_tile(0, 1);
    a_acc = acc_cyc;
    bus.in_data = tile_b;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
    end
    check("t3_second_accept", {ok}, 1'b1);
    b_acc = cyc;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    check("t3_gap", b_acc - a_acc, ROWS + 1);
    check("t3_after_last", b_acc - last_hs_cyc, 1);
    wait_idle();

    // 4: reset while row 7 is stalled
    send_tile(0, 0);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_row_idx == 7) begin bus.out_ready = 1'b0; ok = 1; break; end
    end
    check("t4_reach_row7", {ok}, 1'b1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t4_out_valid", {bus.out_valid}, 1'b0);
    check("t4_in_ready", {bus.in_ready}, 1'b1);
    check("t4_row_idx", bus.out_row_idx, 0);
    check("t4_out_last", {bus.out_last}, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send_tile(1, 0);
    @(negedge clk);
    check("t4_restart_idx", bus.out_row_idx, 0);
    check("t4_restart_c0", {bus.out_data[0]}, 8'h07);
    wait_idle();

    // 5: sparse tile with extreme corners
    send_tile(2, 0);
    @(negedge clk);
    check("t5_r0c0", {bus.out_data[0]}, 8'h80);
`ifdef RELU_TILE_STREAMER_SPARSITY_CNT_EN
    check("t5_zero_cnt", bus.zero_cnt, 37);
`else
    check("t5_zero_cnt", bus.zero_cnt, 0);
`endif
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_last) begin ok = 1; break; end
      @(negedge clk);
    end
    check("t5_last_seen", {ok}, 1'b1);
    check("t5_r14c15", {bus.out_data[COLS-1]}, 8'h7F);
    wait_idle();
    repeat (3) @(negedge clk);
`ifdef RELU_TILE_STREAMER_SPARSITY_CNT_EN
    check("t5_zero_cnt_hold", bus.zero_cnt, 37);
`else
    check("t5_zero_cnt_hold", bus.zero_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
